block_rx_ctrl_8_to_64: RTL and testbench
========================================

Name: block_rx_ctrl_8_to_64

Overview:
Sequences UART receive bytes into 64-bit blocks for the downstream 64-bit datapath, such as the block cipher core. It edge-detects the byte-complete strobe and assembles eight bytes into one block. It then presents the block with a valid/ready handshake. A partial block is discarded on inactivity timeout, and overflow/timeout errors are reported as sticky flags.

Parameters:
TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bytes inside a partial block before it is discarded (must be >= 2)
LSB_FIRST, 1, 1: first byte of a block lands in [7:0]; 0: first byte lands in [63:56]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
rx_data  input  8  received byte, stable while rx_done high
rx_done  input  1  byte-complete level from UART rx; may stay high several cycles; only its rising edge counts
blk_ready  input  1  downstream can accept a block
clr_err  input  1  one-cycle pulse, clears sticky error flags
blk_data  output  64  assembled block, registered
blk_valid  output  1  blk_data holds a complete block
busy  output  1  state != IDLE
byte_cnt  output  4  bytes stored in the current partial block, 0..8
err_overflow  output  1  sticky: byte arrived while a block was waiting and was dropped
err_timeout  output  1  sticky: partial block discarded on timeout

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst asserted (any time, including mid-block): state=IDLE, all outputs 0, byte_cnt=0, timer=0, rx_done_d=0, assembly register 0.
  - A partial block in progress at reset is lost.
- Edge detect: rx_done_d <= rx_done each cycle; rise = rx_done & ~rx_done_d. A held-high rx_done yields exactly one byte.
- Byte lane: byte k (k=0..7, arrival order) goes to [8k+7:8k] if LSB_FIRST=1, else to [63-8k:56-8k].
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE:
    - rise: store rx_data in lane 0, byte_cnt<=1, timer<=0, go COLLECT.
  - COLLECT:
    - rise with byte_cnt<7: store byte in lane byte_cnt, byte_cnt+1, timer<=0.
    - rise with byte_cnt==7: store 8th byte and load blk_data with the full assembled 64 bits in the same edge (no extra cycle). Then byte_cnt<=8, blk_valid<=1, go HOLD.
    - no rise: timer+1. When timer==TIMEOUT_CYCLES-1 and no rise: byte_cnt<=0, timer<=0, err_timeout<=1, go IDLE; the assembly register is not cleared but is fully overwritten by the next block.
    - rise on the timeout cycle: the byte is accepted and the timeout is cancelled.
  - HOLD:
    - blk_valid=1; blk_data held stable until transfer.
    - Transfer = blk_valid & blk_ready, sampled at the rising edge. On transfer: blk_valid<=0, byte_cnt<=0, go IDLE.
    - rise without transfer: byte dropped, err_overflow<=1, stay HOLD.
    - rise and transfer in the same cycle: transfer completes and the byte becomes lane 0 of the next block (byte_cnt<=1, go COLLECT). No error.
    - No timeout in HOLD.
- Latency: 8th rise sampled at edge N -> blk_valid and blk_data valid after edge N. Minimum one cycle between transfers of consecutive blocks.
- Error flags:
  - Set-dominant: an error set in the same cycle as clr_err leaves the flag 1.
  - clr_err has no other effect.
- Timer width: enough to hold TIMEOUT_CYCLES-1; no wrap possible.

Test Plan:
- Reset, then 8 rx_done pulses carrying 0x01..0x08, LSB_FIRST=1, blk_ready=1 -> blk_data=0x0807060504030201, blk_valid high exactly 1 cycle after the 8th edge, byte_cnt returns to 0, busy falls.
- Same bytes with LSB_FIRST=0, rx_done held high 5 cycles per byte -> blk_data=0x0102030405060708, still exactly 8 bytes counted.
- 3 bytes, then idle for TIMEOUT_CYCLES (set to 16) -> err_timeout=1, byte_cnt=0, state IDLE. Next 8 bytes 0xA0..0xA7 -> block 0xA7A6A5A4A3A2A1A0 with no stale data.
- Full block with blk_ready=0, then 1 extra byte 0xFF -> err_overflow=1, blk_data unchanged. clr_err pulse -> flag 0. Raising blk_ready -> one transfer.
- blk_ready rising in the same cycle as the next byte 0x55's edge -> block transferred, byte_cnt=1, next block lane 0=0x55, no error flags.
- rst asserted asynchronously after 4 bytes -> all outputs 0 immediately. The following 8 bytes form a clean block.

Source files
------------

// File: rtl/block_rx_ctrl_8_to_64.sv
// Byte-to-block assembler: collects eight UART receive bytes into a 64-bit
// block and offers it downstream with a valid/ready handshake. A partial
// block is dropped after TIMEOUT_CYCLES idle cycles. Overflow and timeout
// are reported as sticky flags.
module block_rx_ctrl_8_to_64 #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          LSB_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        blk_ready,
    input  logic        clr_err,
    output logic [63:0] blk_data,
    output logic        blk_valid,
    output logic        busy,
    output logic [3:0]  byte_cnt,
    output logic        err_overflow,
    output logic        err_timeout
);

    // Timer only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rx_done_d;
    logic          rise;
    logic          xfer;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [63:0]   assembly;
    logic [63:0]   assembly_nxt;
    logic [63:0]   data_nxt;
    logic          valid_nxt;
    logic [3:0]    cnt_nxt;
    logic          set_ovf;
    logic          set_tmo;

    // Write byte b into the lane belonging to arrival position k.
    function automatic logic [63:0] put_byte(input logic [63:0] word,
                                             input logic [2:0]  k,
                                             input logic [7:0]  b);
        logic [63:0] w;
        logic [2:0]  lane;
        w    = word;
        lane = LSB_FIRST ? k : (3'd7 - k);
        w[{lane, 3'b000} +: 8] = b;
        return w;
    endfunction

    assign rise = rx_done & ~rx_done_d;
    assign xfer = blk_valid & blk_ready;
    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (rise) begin
                    if (byte_cnt == 4'd7) state_nxt = HOLD;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (xfer) state_nxt = rise ? COLLECT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and flag updates for the current state.
    always_comb begin
        cnt_nxt      = byte_cnt;
        timer_nxt    = timer;
        assembly_nxt = assembly;
        data_nxt     = blk_data;
        valid_nxt    = blk_valid;
        set_ovf      = 1'b0;
        set_tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    assembly_nxt = put_byte(assembly, 3'd0, rx_data);
                    cnt_nxt      = 4'd1;
                    timer_nxt    = '0;
                end
            end
            COLLECT: begin
                if (rise) begin
                    assembly_nxt = put_byte(assembly, byte_cnt[2:0], rx_data);
                    cnt_nxt      = byte_cnt + 4'd1;
                    timer_nxt    = '0;
                    // 8th byte goes straight into blk_data on the same edge.
                    if (byte_cnt == 4'd7) begin
                        data_nxt  = assembly_nxt;
                        valid_nxt = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    set_tmo   = 1'b1;
                end else begin
                    timer_nxt = timer + TIMER_ONE;
                end
            end
            HOLD: begin
                if (xfer) begin
                    valid_nxt = 1'b0;
                    if (rise) begin
                        assembly_nxt = put_byte(assembly, 3'd0, rx_data);
                        cnt_nxt      = 4'd1;
                        timer_nxt    = '0;
                    end else begin
                        cnt_nxt = '0;
                    end
                end else if (rise) begin
                    set_ovf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered datapath, edge detector and set-dominant sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done_d    <= 1'b0;
            timer        <= '0;
            assembly     <= '0;
            blk_data     <= '0;
            blk_valid    <= 1'b0;
            byte_cnt     <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            rx_done_d    <= rx_done;
            timer        <= timer_nxt;
            assembly     <= assembly_nxt;
            blk_data     <= data_nxt;
            blk_valid    <= valid_nxt;
            byte_cnt     <= cnt_nxt;
            err_overflow <= set_ovf | (err_overflow & ~clr_err);
            err_timeout  <= set_tmo | (err_timeout & ~clr_err);
        end
    end

endmodule

// File: tb/tb_block_rx_ctrl_8_to_64.sv
// Bench for block_rx_ctrl_8_to_64: an LSB-first and an MSB-first instance
// share one stimulus stream; a queue-based reference model predicts blocks
// and status, and a negedge monitor compares.
module tb_block_rx_ctrl_8_to_64;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        blk_ready;
    logic        clr_err;

    logic [63:0] data_l, data_m;
    logic        valid_l, valid_m, busy_l, busy_m;
    logic [3:0]  cnt_l, cnt_m;
    logic        ovf_l, ovf_m, tmo_l, tmo_m;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_bytes[$];
    logic [63:0] sb_l[$];
    logic [63:0] sb_m[$];
    bit          m_prev, m_wait, m_ovf, m_tmo;
    int          m_idle;

    always #5 clk = ~clk;

    block_rx_ctrl_8_to_64 #(.TIMEOUT_CYCLES(TMO), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .blk_ready(blk_ready), .clr_err(clr_err), .blk_data(data_l),
        .blk_valid(valid_l), .busy(busy_l), .byte_cnt(cnt_l),
        .err_overflow(ovf_l), .err_timeout(tmo_l)
    );

    block_rx_ctrl_8_to_64 #(.TIMEOUT_CYCLES(TMO), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .blk_ready(blk_ready), .clr_err(clr_err), .blk_data(data_m),
        .blk_valid(valid_m), .busy(busy_m), .byte_cnt(cnt_m),
        .err_overflow(ovf_m), .err_timeout(tmo_m)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_bytes.delete();
        sb_l.delete();
        sb_m.delete();
        m_prev = 1'b0;
        m_wait = 1'b0;
        m_ovf  = 1'b0;
        m_tmo  = 1'b0;
        m_idle = 0;
    endtask

    // One clock edge of the behavioural model.
    task automatic model_step();
        bit          rise;
        logic [63:0] bl, bm;
        rise   = rx_done && !m_prev;
        m_prev = rx_done;
        if (m_wait && blk_ready) m_wait = 1'b0;
        if (clr_err) begin
            m_ovf = 1'b0;
            m_tmo = 1'b0;
        end
        if (rise) begin
            if (m_wait) begin
                m_ovf = 1'b1;
            end else begin
                m_bytes.push_back(rx_data);
                m_idle = 0;
                if (m_bytes.size() == 8) begin
                    bl = '0;
                    bm = '0;
                    for (int k = 0; k < 8; k++) begin
                        bl = bl | (64'(m_bytes[k]) << (8 * k));
                        bm = bm | (64'(m_bytes[k]) << (56 - 8 * k));
                    end
                    sb_l.push_back(bl);
                    sb_m.push_back(bm);
                    m_bytes.delete();
                    m_wait = 1'b1;
                end
            end
        end else if (!m_wait && m_bytes.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_bytes.delete();
                m_idle = 0;
                m_tmo  = 1'b1;
            end
        end
    endtask

    // Model advances on every rising edge.
    always @(posedge clk) begin
        if (rst) model_clear();
        else     model_step();
    end

    // Monitor: status every cycle, block data on each handshake.
    always @(negedge clk) begin
        logic [3:0] ecnt;
        ecnt = m_wait ? 4'd8 : 4'(m_bytes.size());
        check("cnt_l", 64'(cnt_l), 64'(ecnt));
        check("cnt_m", 64'(cnt_m), 64'(ecnt));
        check("valid_l", 64'(valid_l), 64'(m_wait));
        check("valid_m", 64'(valid_m), 64'(m_wait));
        check("busy_l", 64'(busy_l), 64'(m_wait || m_bytes.size() != 0));
        check("busy_m", 64'(busy_m), 64'(m_wait || m_bytes.size() != 0));
        check("ovf_l", 64'(ovf_l), 64'(m_ovf));
        check("ovf_m", 64'(ovf_m), 64'(m_ovf));
        check("tmo_l", 64'(tmo_l), 64'(m_tmo));
        check("tmo_m", 64'(tmo_m), 64'(m_tmo));
        if (valid_l && blk_ready) begin
            if (sb_l.size() == 0) check("xfer_l_unexpected", 64'(valid_l), 64'd0);
            else                  check("blk_l", data_l, sb_l.pop_front());
        end
        if (valid_m && blk_ready) begin
            if (sb_m.size() == 0) check("xfer_m_unexpected", 64'(valid_m), 64'd0);
            else                  check("blk_m", data_m, sb_m.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        tick(hold);
        rx_done = 1'b0;
        tick(gap);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_data = '0; rx_done = 1'b0; blk_ready = 1'b0; clr_err = 1'b0;
        model_clear();
        tick(3);
        check("rst_data_l", data_l, 64'd0);
        check("rst_valid_m", 64'(valid_m), 64'd0);
        rst = 1'b0;
        tick(1);

        // Basic block, single-cycle strobes
        blk_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1, 1);
        tick(2);
        check("t1_l", data_l, 64'h0807060504030201);
        check("t1_m", data_m, 64'h0102030405060708);
        check("t1_busy", 64'(busy_l), 64'd0);

        // Strobe held high for several cycles
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 5, 1);
        tick(2);
        check("t2_m", data_m, 64'h0102030405060708);
        check("t2_cnt", 64'(cnt_m), 64'd0);

        // Timeout discards a partial block
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1, 1);
        tick(20);
        check("t3_tmo", 64'(tmo_l), 64'd1);
        check("t3_cnt", 64'(cnt_l), 64'd0);
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1, 1);
        tick(2);
        check("t3_l", data_l, 64'hA7A6A5A4A3A2A1A0);
        check("t3_m", data_m, 64'hA0A1A2A3A4A5A6A7);

        // Overflow while a block waits
        blk_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 1, 1);
        send_byte(8'hFF, 1, 1);
        check("t4_ovf", 64'(ovf_l), 64'd1);
        check("t4_hold_l", data_l, 64'h1817161514131211);
        pulse_clr();
        check("t4_clr", 64'(ovf_l | tmo_l), 64'd0);
        blk_ready = 1'b1;
        tick(2);
        blk_ready = 1'b0;

        // Transfer and next first byte on the same edge
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 1, 1);
        rx_data = 8'h55; rx_done = 1'b1; blk_ready = 1'b1;
        tick(1);
        rx_done = 1'b0; blk_ready = 1'b0;
        check("t5_cnt", 64'(cnt_l), 64'd1);
        check("t5_flags", 64'({ovf_l, tmo_l, ovf_m, tmo_m}), 64'd0);
        tick(1);
        for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i), 1, 1);
        blk_ready = 1'b1;
        tick(2);
        check("t5_l", data_l, 64'h1615141312111055);
        check("t5_m", data_m, 64'h5510111213141516);

        // Asynchronous reset mid-block
        for (int i = 0; i < 4; i++) send_byte(8'h77, 1, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_cnt", 64'(cnt_l), 64'd0);
        check("t6_rst_busy", 64'(busy_m), 64'd0);
        check("t6_rst_data", data_l, 64'd0);
        model_clear();
        tick(2);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i), 1, 1);
        tick(2);
        check("t6_l", data_l, 64'h2827262524232221);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rx_done = 1'b0;
                tick(TMO + 2);
            end
            if (!rx_done) rx_data = 8'($urandom);
            rx_done   = ($urandom_range(0, 1) == 1);
            blk_ready = ($urandom_range(0, 2) != 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            tick(1);
        end

        // Drain
        rx_done = 1'b0; clr_err = 1'b0; blk_ready = 1'b1;
        tick(TMO + 4);
        check("sb_l_empty", 64'(sb_l.size()), 64'd0);
        check("sb_m_empty", 64'(sb_m.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
